// File: rtl/nvm_word_arbiter.sv
// -----------------------------------------------------------------------------
// nvm_word_arbiter
//
// Shares the single byte-wide NVM ROM read port between two 16-bit word-read
// requesters. Requester A is the EERD-style register-read path and requester B
// is the boot/config loader. Each word read becomes two byte reads: the low
// byte at the even byte address, then the high byte at the odd one. Grants are
// round-robin. The assembled word is returned with a one-cycle ack strobe.
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   a_req, a_waddr    : requester A request strobe and word address
//   a_busy            : A has a pending or in-service request
//   a_ack, a_data     : A completion strobe and last word read for A
//   b_*               : same set of ports for requester B
//   rom_addr          : registered byte address to the ROM
//   rom_data          : ROM byte, valid the cycle after rom_addr is presented
//   dbg_state         : current FSM state (0 IDLE, 1 RD0, 2 RD1, 3 RD2, 4 ACK)
//
// Request handshake (identical for A and B):
//   x_req is a one-cycle strobe. It is accepted in any cycle where x_busy is
//   low, and x_waddr is sampled in that same cycle. A strobe raised while
//   x_busy is high is dropped and leaves no trace. x_busy rises the cycle after
//   acceptance and stays high until the ack cycle. In the ack cycle x_busy is
//   already low, so the requester may issue its next request alongside the ack.
//   x_ack is high for exactly one cycle, and x_data is valid from that cycle
//   until the next ack to the same requester.
//
// Timing: a request accepted and granted in IDLE cycle 0 is acked in cycle 4.
// Back-to-back services are 5 cycles apart.
// -----------------------------------------------------------------------------
module nvm_word_arbiter #(
  parameter int WADDR_W = 12,
  parameter int BADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic [WADDR_W-1:0] a_waddr,
  output logic               a_busy,
  output logic               a_ack,
  output logic [15:0]        a_data,
  input  logic               b_req,
  input  logic [WADDR_W-1:0] b_waddr,
  output logic               b_busy,
  output logic               b_ack,
  output logic [15:0]        b_data,
  output logic [BADDR_W-1:0] rom_addr,
  input  logic [7:0]         rom_data,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_ACK  = 3'd4
  } state_t;

  // Requester encoding used by grant_q and last_grant_q.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t             state_q;
  logic               grant_q;
  logic               last_grant_q;
  logic               pending_a_q;
  logic               pending_b_q;
  logic [WADDR_W-1:0] a_waddr_q;
  logic [WADDR_W-1:0] b_waddr_q;
  logic [7:0]         lo_q;

  logic               acc_a;
  logic               acc_b;
  logic               cand_a;
  logic               cand_b;
  logic               pick_b;
  logic               any_cand;
  logic [WADDR_W-1:0] sel_waddr;

  // Byte address is {zero pad, word address, byte select}. There is no carry
  // into the pad bits, so word address all-ones stays inside its window.
  function automatic logic [BADDR_W-1:0] byte_addr(input logic [WADDR_W-1:0] w,
                                                   input logic sel);
    logic [BADDR_W-1:0] r;
    r            = '0;
    r[WADDR_W:1] = w;
    r[0]         = sel;
    return r;
  endfunction

  logic in_read;
  assign in_read = (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_RD2);

  assign a_busy    = pending_a_q || (in_read && (grant_q == GRANT_A));
  assign b_busy    = pending_b_q || (in_read && (grant_q == GRANT_B));
  assign dbg_state = state_q;

  always_comb begin
    acc_a    = a_req && !a_busy;
    acc_b    = b_req && !b_busy;
    // A request accepted this cycle competes in IDLE immediately.
    cand_a   = pending_a_q || acc_a;
    cand_b   = pending_b_q || acc_b;
    any_cand = cand_a || cand_b;
    // On a tie, grant the requester that was not granted last.
    pick_b   = cand_b && (!cand_a || (last_grant_q == GRANT_A));
    // A freshly accepted request has not reached its address register yet,
    // so its address is taken straight from the input port.
    if (pick_b) sel_waddr = acc_b ? b_waddr : b_waddr_q;
    else        sel_waddr = acc_a ? a_waddr : a_waddr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= GRANT_A;
      last_grant_q <= GRANT_B;
      pending_a_q  <= 1'b0;
      pending_b_q  <= 1'b0;
      a_waddr_q    <= '0;
      b_waddr_q    <= '0;
      lo_q         <= '0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_data       <= '0;
      b_data       <= '0;
      rom_addr     <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (acc_a) begin
        a_waddr_q   <= a_waddr;
        pending_a_q <= 1'b1;
      end
      if (acc_b) begin
        b_waddr_q   <= b_waddr;
        pending_b_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (any_cand) begin
            grant_q      <= pick_b;
            last_grant_q <= pick_b;
            rom_addr     <= byte_addr(sel_waddr, 1'b0);
            state_q      <= S_RD0;
          end
        end
        S_RD0: begin
          // The ROM samples the even address in this cycle; the odd address
          // differs only in bit 0.
          rom_addr[0] <= 1'b1;
          state_q     <= S_RD1;
        end
        S_RD1: begin
          lo_q    <= rom_data;
          state_q <= S_RD2;
        end
        S_RD2: begin
          if (grant_q == GRANT_B) begin
            b_data      <= {rom_data, lo_q};
            pending_b_q <= 1'b0;
            b_ack       <= 1'b1;
          end else begin
            a_data      <= {rom_data, lo_q};
            pending_a_q <= 1'b0;
            a_ack       <= 1'b1;
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_word_arbiter.sv
module tb_nvm_word_arbiter;

  localparam int WADDR_W = 12;
  localparam int BADDR_W = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               a_req = 1'b0;
  logic [WADDR_W-1:0] a_waddr = '0;
  logic               a_busy;
  logic               a_ack;
  logic [15:0]        a_data;
  logic               b_req = 1'b0;
  logic [WADDR_W-1:0] b_waddr = '0;
  logic               b_busy;
  logic               b_ack;
  logic [15:0]        b_data;
  logic [BADDR_W-1:0] rom_addr;
  logic [7:0]         rom_data;
  logic [2:0]         dbg_state;

  nvm_word_arbiter #(.WADDR_W(WADDR_W), .BADDR_W(BADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_waddr(a_waddr), .a_busy(a_busy), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_waddr(b_waddr), .b_busy(b_busy), .b_ack(b_ack), .b_data(b_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
  );

  // ROM model: one-cycle read latency.
  logic [7:0] rom [0:65535];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output bundle {a_busy, b_busy, a_ack, b_ack, a_data, b_data, rom_addr}.
  function automatic logic [63:0] outs();
    return {12'h0, a_busy, b_busy, a_ack, b_ack, a_data, b_data, rom_addr};
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_waddr = '0; b_waddr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic r, input logic ar, input logic [11:0] aw,
                       input logic br, input logic [11:0] bw);
    @(posedge clk); #1;
    rst = r; a_req = ar; a_waddr = aw; b_req = br; b_waddr = bw;
  endtask

  typedef struct {
    logic        rst;
    logic        a_req;
    logic [11:0] a_w;
    logic        b_req;
    logic [11:0] b_w;
    logic [3:0]  flags;   // {a_busy, b_busy, a_ack, b_ack}
    logic [15:0] a_d;
    logic [15:0] b_d;
    logic [15:0] ra;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [0:NVEC-1];

  initial begin
    int          ack_cnt;
    int          b_ack_cnt;
    int          nsvc;
    int          ack_cyc;
    logic        saw_a;
    logic [15:0] ra1;
    logic [15:0] ra2;
    logic        who  [4];
    int          when [4];
    logic [15:0] dat  [4];
    logic [15:0] exp_hi;

    for (int i = 0; i < 65536; i++) begin
      logic [15:0] ai;
      ai = i[15:0];
      rom[i] = ai[7:0] ^ ai[15:8] ^ 8'h5A;
    end
    rom[0] = 8'h00; rom[1] = 8'h11; rom[2] = 8'h22;
    rom[3] = 8'h33; rom[4] = 8'h44; rom[5] = 8'h55;

    // Single A read of word 0, then a reset, then simultaneous A(1)/B(2).
    vecs[0]  = '{0, 1, 12'h000, 0, 12'h000, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 12'h000, 0, 12'h000, 4'b1000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 0, 12'h000, 0, 12'h000, 4'b1000, 16'h0000, 16'h0000, 16'h0001};
    vecs[3]  = '{0, 0, 12'h000, 0, 12'h000, 4'b1000, 16'h0000, 16'h0000, 16'h0001};
    vecs[4]  = '{0, 0, 12'h000, 0, 12'h000, 4'b0010, 16'h1100, 16'h0000, 16'h0001};
    vecs[5]  = '{0, 0, 12'h000, 0, 12'h000, 4'b0000, 16'h1100, 16'h0000, 16'h0001};
    vecs[6]  = '{1, 0, 12'h000, 0, 12'h000, 4'b0000, 16'h1100, 16'h0000, 16'h0001};
    vecs[7]  = '{0, 1, 12'h001, 1, 12'h002, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[8]  = '{0, 0, 12'h000, 0, 12'h000, 4'b1100, 16'h0000, 16'h0000, 16'h0002};
    vecs[9]  = '{0, 0, 12'h000, 0, 12'h000, 4'b1100, 16'h0000, 16'h0000, 16'h0003};
    vecs[10] = '{0, 0, 12'h000, 0, 12'h000, 4'b1100, 16'h0000, 16'h0000, 16'h0003};
    vecs[11] = '{0, 0, 12'h000, 0, 12'h000, 4'b0110, 16'h3322, 16'h0000, 16'h0003};
    vecs[12] = '{0, 0, 12'h000, 0, 12'h000, 4'b0100, 16'h3322, 16'h0000, 16'h0003};
    vecs[13] = '{0, 0, 12'h000, 0, 12'h000, 4'b0100, 16'h3322, 16'h0000, 16'h0004};
    vecs[14] = '{0, 0, 12'h000, 0, 12'h000, 4'b0100, 16'h3322, 16'h0000, 16'h0005};
    vecs[15] = '{0, 0, 12'h000, 0, 12'h000, 4'b0100, 16'h3322, 16'h0000, 16'h0005};
    vecs[16] = '{0, 0, 12'h000, 0, 12'h000, 4'b0001, 16'h3322, 16'h5544, 16'h0005};
    vecs[17] = '{0, 0, 12'h000, 0, 12'h000, 4'b0000, 16'h3322, 16'h5544, 16'h0005};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_outputs", outs(), 64'h0);
    check("reset_state", {61'h0, dbg_state}, 64'h0);

    // Table-driven vectors, one full-output comparison per cycle
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].a_req, vecs[i].a_w, vecs[i].b_req, vecs[i].b_w);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {12'h0, vecs[i].flags, vecs[i].a_d, vecs[i].b_d, vecs[i].ra});
    end

    // Both requesters re-request in every ack cycle: A,B,A,B, 5 cycles apart
    do_reset();
    nsvc = 0;
    drive(0, 1, 12'h001, 1, 12'h002);
    for (int cyc = 1; cyc <= 40 && nsvc < 4; cyc++) begin
      drive(0, 0, 12'h001, 0, 12'h002);
      if (a_ack || b_ack) begin
        who[nsvc]  = b_ack;
        when[nsvc] = cyc;
        dat[nsvc]  = b_ack ? b_data : a_data;
        nsvc++;
        a_req = 1'b1;
        b_req = 1'b1;
      end
    end
    check("rr_service_count", nsvc, 4);
    for (int i = 0; i < nsvc; i++) begin
      check($sformatf("rr_who%0d", i), {63'h0, who[i]}, (i % 2 == 1) ? 64'h1 : 64'h0);
      check($sformatf("rr_when%0d", i), when[i], 4 + 5 * i);
      check($sformatf("rr_data%0d", i), {48'h0, dat[i]}, (i % 2 == 1) ? 64'h5544 : 64'h3322);
    end

    // a_req pulsed while busy is dropped
    drive(0, 0, 12'h000, 0, 12'h000);
    do_reset();
    ack_cnt = 0;
    saw_a = 1'b0;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      drive(0, (cyc == 0 || cyc == 2), (cyc == 0) ? 12'h001 : 12'h005, 0, 12'h000);
      if (a_ack) ack_cnt++;
      if (rom_addr == 16'h000A) saw_a = 1'b1;
    end
    check("drop_ack_count", ack_cnt, 1);
    check("drop_data", {48'h0, a_data}, 64'h3322);
    check("drop_no_addr_0A", {63'h0, saw_a}, 64'h0);
    check("drop_a_busy_end", {63'h0, a_busy}, 64'h0);

    // Address wrap on B with word address all-ones
    do_reset();
    ra1 = '0; ra2 = '0; ack_cyc = -1;
    for (int cyc = 0; cyc <= 7; cyc++) begin
      drive(0, 0, 12'h000, (cyc == 0), 12'hFFF);
      if (cyc == 1) ra1 = rom_addr;
      if (cyc == 2) ra2 = rom_addr;
      if (b_ack && ack_cyc < 0) ack_cyc = cyc;
    end
    exp_hi = {rom[16'h1FFF], rom[16'h1FFE]};
    check("wrap_addr_lo", {48'h0, ra1}, 64'h1FFE);
    check("wrap_addr_hi", {48'h0, ra2}, 64'h1FFF);
    check("wrap_ack_cycle", ack_cyc, 4);
    check("wrap_b_data", {48'h0, b_data}, {48'h0, exp_hi});
    check("wrap_a_data", {48'h0, a_data}, 64'h0);

    // Reset during RD1 of an A read with B pending
    do_reset();
    ack_cnt = 0;
    drive(0, 1, 12'h001, 0, 12'h000);      // cycle 0: A granted
    drive(0, 0, 12'h000, 1, 12'h002);      // cycle 1: B becomes pending
    check("midrst_b_busy", {63'h0, b_busy}, 64'h0);
    drive(1, 0, 12'h000, 0, 12'h000);      // cycle 2 (RD1): reset
    drive(0, 0, 12'h000, 0, 12'h000);      // cycle 3
    check("midrst_outputs", outs(), 64'h0);
    check("midrst_state", {61'h0, dbg_state}, 64'h0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(0, 0, 12'h000, 0, 12'h000);
      if (a_ack || b_ack) ack_cnt++;
    end
    check("midrst_no_ack", ack_cnt, 0);
    b_ack_cnt = 0;
    ack_cyc = -1;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      drive(0, (cyc == 0), 12'h000, 0, 12'h000);
      if (a_ack && ack_cyc < 0) ack_cyc = cyc;
      if (b_ack) b_ack_cnt++;
    end
    check("midrst_fresh_ack_cycle", ack_cyc, 4);
    check("midrst_fresh_data", {48'h0, a_data}, 64'h1100);
    check("midrst_no_b_ack", b_ack_cnt, 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
